// File: rtl/sys_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sys_pkg
// Purpose  : Shared definitions for the system controller: command byte
//            codes, FSM state encoding and the RF addresses that receive the
//            ALU operands.
// Revision : 1.0 - initial release
// ============================================================================
package sys_pkg;

    // Command bytes recognised in IDLE
    localparam logic [7:0] c_cmd_rf_wr     = 8'hAA;
    localparam logic [7:0] c_cmd_rf_rd     = 8'hBB;
    localparam logic [7:0] c_cmd_alu_op    = 8'hCC;
    localparam logic [7:0] c_cmd_alu_no_op = 8'hDD;

    // RF locations that hold the ALU operands
    localparam int c_op_a_addr = 0;
    localparam int c_op_b_addr = 1;

    // FSM state encoding
    localparam logic [3:0] c_st_idle     = 4'd0;
    localparam logic [3:0] c_st_wr_addr  = 4'd1;
    localparam logic [3:0] c_st_wr_data  = 4'd2;
    localparam logic [3:0] c_st_rd_addr  = 4'd3;
    localparam logic [3:0] c_st_rd_wait  = 4'd4;
    localparam logic [3:0] c_st_rd_push  = 4'd5;
    localparam logic [3:0] c_st_op_a     = 4'd6;
    localparam logic [3:0] c_st_op_b     = 4'd7;
    localparam logic [3:0] c_st_alu_fn   = 4'd8;
    localparam logic [3:0] c_st_alu_wait = 4'd9;
    localparam logic [3:0] c_st_push_lo  = 4'd10;
    localparam logic [3:0] c_st_push_hi  = 4'd11;

    typedef enum logic [3:0] {
        ST_IDLE     = c_st_idle,
        ST_WR_ADDR  = c_st_wr_addr,
        ST_WR_DATA  = c_st_wr_data,
        ST_RD_ADDR  = c_st_rd_addr,
        ST_RD_WAIT  = c_st_rd_wait,
        ST_RD_PUSH  = c_st_rd_push,
        ST_OP_A     = c_st_op_a,
        ST_OP_B     = c_st_op_b,
        ST_ALU_FN   = c_st_alu_fn,
        ST_ALU_WAIT = c_st_alu_wait,
        ST_PUSH_LO  = c_st_push_lo,
        ST_PUSH_HI  = c_st_push_hi
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sys_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sys_ctrl
// Purpose  : Command decoder/sequencer between the UART RX frames, the
//            register file, the ALU and the TX FIFO.
// Ports    : CLK, RST (sync, active-high)
//            RX_P_DATA/RX_D_VLD       - received frames
//            RdData/RdData_Vaild      - RF read response
//            ALU_OUT/ALU_OUT_VLD      - ALU result
//            FULL                     - TX FIFO full
//            Address/WrData/WR_En/RD_EN          - RF control
//            ALU_FUN/ALU_EN/CLK_GATE_EN          - ALU control
//            TX_P_DATA/W_INC                     - TX FIFO write
//            ERR_CNT (only with SYS_CTRL_ERR_CNT_EN) - dropped-frame count
// Config   : define SYS_CTRL_ERR_CNT_EN to add the saturating ERR_CNT port.
// Revision : 1.0 - initial release
// ============================================================================
module sys_ctrl
    import sys_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int RF_ADDR_WIDTH = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     RX_P_DATA,
    input  logic                      RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]     RdData,
    input  logic                      RdData_Vaild,
    input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
    input  logic                      ALU_OUT_VLD,
    input  logic                      FULL,
    output logic [RF_ADDR_WIDTH-1:0]  Address,
    output logic [DATA_WIDTH-1:0]     WrData,
    output logic                      WR_En,
    output logic                      RD_EN,
    output logic [3:0]                ALU_FUN,
    output logic                      ALU_EN,
    output logic                      CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]     TX_P_DATA,
    output logic                      W_INC
`ifdef SYS_CTRL_ERR_CNT_EN
    ,
    output logic [7:0]                ERR_CNT
`endif
);

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_tx_data;  // byte presented to the FIFO
    logic [DATA_WIDTH-1:0]   r_alu_hi;   // upper ALU byte waiting for PUSH_HI
    logic                    w_push_state;

    // W_INC is gated combinationally with FULL so that it can never be high
    // in a cycle where the FIFO reports full, even if FULL changes between
    // edges. The FSM leaves a push state on exactly the same condition, so
    // each byte is written once.
    assign w_push_state = (r_state == ST_RD_PUSH) || (r_state == ST_PUSH_LO) ||
                          (r_state == ST_PUSH_HI);
    assign W_INC        = w_push_state && !FULL;
    assign TX_P_DATA    = r_tx_data;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_tx_data   <= '0;
            r_alu_hi    <= '0;
            Address     <= '0;
            WrData      <= '0;
            WR_En       <= 1'b0;
            RD_EN       <= 1'b0;
            ALU_FUN     <= 4'd0;
            ALU_EN      <= 1'b0;
            CLK_GATE_EN <= 1'b0;
        end else begin
            WR_En  <= 1'b0;
            RD_EN  <= 1'b0;
            ALU_EN <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (RX_D_VLD) begin
                        case (RX_P_DATA)
                            DATA_WIDTH'(c_cmd_rf_wr):     r_state <= ST_WR_ADDR;
                            DATA_WIDTH'(c_cmd_rf_rd):     r_state <= ST_RD_ADDR;
                            DATA_WIDTH'(c_cmd_alu_op):    r_state <= ST_OP_A;
                            DATA_WIDTH'(c_cmd_alu_no_op): r_state <= ST_ALU_FN;
                            default:                      r_state <= ST_IDLE;
                        endcase
                    end
                end
                ST_WR_ADDR: begin
                    if (RX_D_VLD) begin
                        Address <= RX_P_DATA[RF_ADDR_WIDTH-1:0];
                        r_state <= ST_WR_DATA;
                    end
                end
                ST_WR_DATA: begin
                    if (RX_D_VLD) begin
                        WrData  <= RX_P_DATA;
                        WR_En   <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                ST_RD_ADDR: begin
                    if (RX_D_VLD) begin
                        Address <= RX_P_DATA[RF_ADDR_WIDTH-1:0];
                        RD_EN   <= 1'b1;
                        r_state <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (RdData_Vaild) begin
                        r_tx_data <= RdData;
                        r_state   <= ST_RD_PUSH;
                    end
                end
                ST_RD_PUSH: begin
                    if (!FULL) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_OP_A: begin
                    if (RX_D_VLD) begin
                        Address <= RF_ADDR_WIDTH'(c_op_a_addr);
                        WrData  <= RX_P_DATA;
                        WR_En   <= 1'b1;
                        r_state <= ST_OP_B;
                    end
                end
                ST_OP_B: begin
                    if (RX_D_VLD) begin
                        Address <= RF_ADDR_WIDTH'(c_op_b_addr);
                        WrData  <= RX_P_DATA;
                        WR_En   <= 1'b1;
                        r_state <= ST_ALU_FN;
                    end
                end
                ST_ALU_FN: begin
                    if (RX_D_VLD) begin
                        ALU_FUN     <= RX_P_DATA[3:0];
                        ALU_EN      <= 1'b1;
                        CLK_GATE_EN <= 1'b1;
                        r_state     <= ST_ALU_WAIT;
                    end
                end
                ST_ALU_WAIT: begin
                    // The ALU clock stays ungated until its result arrives
                    if (ALU_OUT_VLD) begin
                        r_tx_data   <= ALU_OUT[DATA_WIDTH-1:0];
                        r_alu_hi    <= ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
                        CLK_GATE_EN <= 1'b0;
                        r_state     <= ST_PUSH_LO;
                    end
                end
                ST_PUSH_LO: begin
                    if (!FULL) begin
                        r_tx_data <= r_alu_hi;
                        r_state   <= ST_PUSH_HI;
                    end
                end
                ST_PUSH_HI: begin
                    if (!FULL) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef SYS_CTRL_ERR_CNT_EN
    logic w_cmd_known;
    logic w_drop;
    logic [7:0] r_err_cnt;

    assign w_cmd_known = (RX_P_DATA == DATA_WIDTH'(c_cmd_rf_wr))  ||
                         (RX_P_DATA == DATA_WIDTH'(c_cmd_rf_rd))  ||
                         (RX_P_DATA == DATA_WIDTH'(c_cmd_alu_op)) ||
                         (RX_P_DATA == DATA_WIDTH'(c_cmd_alu_no_op));

    // A frame is dropped when it is an unknown command in IDLE or arrives
    // while the FSM is waiting on the RF, the ALU or the FIFO.
    assign w_drop = RX_D_VLD &&
                    (((r_state == ST_IDLE) && !w_cmd_known) ||
                     (r_state == ST_RD_WAIT)  || (r_state == ST_RD_PUSH) ||
                     (r_state == ST_ALU_WAIT) || (r_state == ST_PUSH_LO) ||
                     (r_state == ST_PUSH_HI));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_err_cnt <= 8'd0;
        end else if (w_drop && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign ERR_CNT = r_err_cnt;
`endif

endmodule
`default_nettype wire
